// File: rtl/beta_pkg.sv
// Shared definitions for the Beta fetch/PC slice: PCSEL codes, default
// vectors and the fetch FSM state type.
package beta_pkg;

  // PCSEL encodings driven by the control unit
  localparam logic [2:0] PCSEL_PC4   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JMP   = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;
  localparam logic [2:0] PCSEL_XADR  = 3'd4;

  // Default vectors; bit 31 is the supervisor bit
  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/beta_pc_next.sv
// Combinational next-PC mux. Address arithmetic runs in the 31-bit
// address space; the supervisor bit is carried separately so that only
// JMP can clear it and nothing but the fixed vectors can set it.
module beta_pc_next
  import beta_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input  logic [31:0] pc,
  input  logic [15:0] offset,
  input  logic [31:0] jt,
  input  logic [2:0]  pcsel,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  logic [30:0] br_disp;
  logic [31:0] sel_pc;

  // Word offset sign-extended from bit 15 and scaled to bytes
  assign br_disp       = {{13{offset[15]}}, offset, 2'b00};
  assign pc_plus4      = {pc[31], pc[30:0] + 31'd4};
  assign branch_target = {pc[31], pc_plus4[30:0] + br_disp};

  // Select the PC source from the control unit's PCSEL code
  always_comb begin
    // NOTE: default assignment first so no path leaves sel_pc unassigned (no latch).
    sel_pc = ILLOP_VEC;
    case (pcsel)
      PCSEL_PC4:   sel_pc = pc_plus4;
      PCSEL_BR:    sel_pc = branch_target;
      PCSEL_JMP:   sel_pc = {pc[31] & jt[31], jt[30:0]};
      PCSEL_ILLOP: sel_pc = ILLOP_VEC;
      PCSEL_XADR:  sel_pc = XADR_VEC;
      default:     sel_pc = ILLOP_VEC;
    endcase
  end

  // Instruction addresses are always word aligned
  assign next_pc = {sel_pc[31:2], 2'b00};

endmodule

// File: rtl/beta_ifetch.sv
// Beta instruction fetch / PC stage. Issues one fetch at a time, holds the
// fetched word for the control unit, and advances the PC on instr_ack.
module beta_ifetch
  import beta_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic [2:0]  pcsel,
  input  logic [31:0] jt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  ifetch_state_t state;
  logic [31:0]   next_pc;

  beta_pc_next #(
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_pc_next (
    .pc            (pc),
    .offset        (instruction[15:0]),
    .jt            (jt),
    .pcsel         (pcsel),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  // The fetch address is the PC itself, stable for the whole request
  assign imem_addr = pc;

  // Fetch FSM with PC and instruction registers; reset dominates
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state       <= ST_RST;
      pc          <= RESET_VEC;
      instruction <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          imem_req <= 1'b1;
          state    <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ack) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= ST_RST;
        end
      endcase
    end
  end

endmodule

// File: doc/beta_ifetch.md
Name: beta_ifetch

Overview:
- Instruction fetch / PC stage directly upstream of the control unit (CU).
- Holds the program counter and fetches one 32-bit instruction at a time from instruction memory over a req/ready handshake.
- Presents the instruction word to the CU and advances the PC according to the CU's PCSEL when the execute side acknowledges.
- Also supplies PC+4 and the branch target to the datapath.

Parameters:
RESET_VEC, 32'h8000_0000, PC loaded on reset (supervisor bit set)
ILLOP_VEC, 32'h8000_0004, PC target for PCSEL=3 and for undefined PCSEL codes
XADR_VEC, 32'h8000_0008, PC target for PCSEL=4 (interrupt)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, held until imem_ready
imem_addr  out  32  fetch address (= pc), stable while imem_req=1
imem_ready  in  1  imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instruction  out  32  registered instruction to CU
instr_valid  out  1  instruction holds a fetched, unconsumed word
instr_ack  in  1  execute stage consumes instruction this cycle; pcsel/jt valid
pcsel  in  3  from CU: 0 PC+4, 1 branch, 2 JMP, 3 ILLOP, 4 XADR
jt  in  32  JMP target (Ra register value)
pc  out  32  current PC
pc_plus4  out  32  pc+4, supervisor bit preserved
branch_target  out  32  pc_plus4 + 4*SXT(instruction[15:0])

Behaviour:
- Reset, synchronous and active-high, dominates everything:
  - pc=RESET_VEC, instruction=0, instr_valid=0, imem_req=0, state=RST.
  - Reset mid-fetch drops imem_req on the next edge.
  - An imem_ready seen in RST is ignored.
- FSM states: RST, FETCH, HOLD.
  - RST → FETCH one cycle after reset deasserts.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready=1: instruction<=imem_rdata, instr_valid<=1, go HOLD. Latency is 1 cycle from ready to valid.
  - HOLD: imem_req=0. instruction and pc are stable. On instr_ack=1: pc<=next_pc, instr_valid<=0, go FETCH.
  - instr_ack while instr_valid=0 is ignored.
- One outstanding request only. No prefetch.
- Minimum 2 cycles per instruction with zero-wait memory.
- next_pc rules; bits [1:0] are always 0:
  - pcsel=0: {pc[31], pc_plus4[30:0]}, where pc_plus4[30:0] = pc[30:0]+4 and wraps within the 31-bit space.
  - pcsel=1: {pc[31], branch_target[30:0]}. Offset is sign-extended from instruction[15], shifted left 2. Wrap modulo 2^31.
  - pcsel=2: {pc[31] & jt[31], jt[30:2], 2'b00}. JMP may clear but never set the supervisor bit.
  - pcsel=3: ILLOP_VEC. pcsel=4: XADR_VEC. pcsel=5..7: ILLOP_VEC.
- pc_plus4 and branch_target are combinational from pc and instruction. They are valid whenever instr_valid=1.
- imem_ready arriving in HOLD is ignored (protocol violation). No state change.

Decomposition:
- Shared package beta_pkg:
  - PCSEL encodings (PCSEL_PC4, PCSEL_BR, PCSEL_JMP, PCSEL_ILLOP, PCSEL_XADR)
  - default vector constants
  - ifetch FSM state enum (RST, FETCH, HOLD)
- One natural sub-module, beta_pc_next: a purely combinational next-PC mux. It takes pc, instruction[15:0], jt and pcsel, and produces next_pc, pc_plus4 and branch_target.
- FSM, PC register and instruction register stay in beta_ifetch.

Test Plan:
- Reset release, memory returns 32'h8000_0000 word on first ready → imem_addr=32'h8000_0000; instr_valid=1 one cycle after ready; ack with pcsel=0 → next imem_addr=32'h8000_0004.
- pc=32'h0000_0100, instruction[15:0]=16'hFFFE, ack pcsel=1 → pc=32'h0000_00FC. Repeat with offset 16'h0003 → pc=32'h0000_0110.
- JMP from supervisor pc=32'h8000_0010, jt=32'h0000_2003, pcsel=2 → pc=32'h0000_2000. From user pc, jt=32'h8000_0040 → pc=32'h0000_0040.
- pcsel=3, 4 and 6 on separate acks → pc=32'h8000_0004, 32'h8000_0008, 32'h8000_0004.
- Memory with 3 wait cycles → imem_req and imem_addr stable for all 4 cycles. instr_ack held high during FETCH has no effect. Reset asserted during the wait → imem_req=0 next cycle, pc=RESET_VEC. A late imem_ready is ignored; instr_valid stays 0.
- Wrap: pc=32'h7FFF_FFFC, pcsel=0 → pc=32'h0000_0000. pc=32'hFFFF_FFFC, pcsel=0 → pc=32'h8000_0000.
